// File: rtl/descr_pkg.sv
// Shared types and widths for the additive descrambler and its LFSR.
package descr_pkg;

  typedef enum logic [1:0] {HUNT, LOCKED} descr_state_t;

  localparam int unsigned LFSR_W    = 32;
  localparam int unsigned ERR_CNT_W = 16;
  localparam int unsigned MISS_W    = 4;

  // Keystream bit: parity of the tapped LFSR bits.
  function automatic logic ks_of(input logic [LFSR_W-1:0] state,
                                 input logic [LFSR_W-1:0] poly);
    ks_of = ^(state & poly);
  endfunction

endpackage

// File: rtl/descr_lfsr.sv
// Seedable Fibonacci-style LFSR producing one keystream bit per step.
// Shared between the transmit scrambler and the receive descrambler.
module descr_lfsr
  import descr_pkg::*;
#(
  parameter logic [LFSR_W-1:0] POLY = 32'h0000_0060,
  parameter logic [LFSR_W-1:0] INIT = 32'h0000_007F
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic step,
  output logic ks_c
);

  logic [LFSR_W-1:0] lfsr_q;

  assign ks_c = ks_of(lfsr_q, POLY);

  // Seed load wins over a step so every frame starts from the same state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= '0;
    end else if (load) begin
      lfsr_q <= INIT;
    end else if (step) begin
      lfsr_q <= {lfsr_q[LFSR_W-2:0], ks_c};
    end
  end

endmodule

// File: rtl/additive_descrambler.sv
// Frame-synchronising additive descrambler: sync correlator, bit counter, lock FSM, output register.
// Optional saturating sync-miss counter port enabled by defining DESCR_ERR_CNT_EN.
module additive_descrambler
  import descr_pkg::*;
#(
  parameter logic [LFSR_W-1:0] POLY        = 32'h0000_0060,
  parameter logic [LFSR_W-1:0] INIT        = 32'h0000_007F,
  parameter logic [31:0]       SYNC_WORD   = 32'h1ACF_FC1D,
  parameter int unsigned       SYNC_LEN    = 32,
  parameter int unsigned       FRAME_LEN   = 256,
  parameter int unsigned       LOSS_THRESH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  input  logic in_valid,
  input  logic resync,
  output logic out,
  output logic out_valid,
  output logic frame_start,
  output logic locked
`ifdef DESCR_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] sync_err_cnt
`endif
);

  localparam int unsigned CNT_W   = $clog2(FRAME_LEN);
  localparam int unsigned PAY_LEN = FRAME_LEN - SYNC_LEN;

  localparam logic [CNT_W-1:0]    PAY_END  = CNT_W'(PAY_LEN);
  localparam logic [CNT_W-1:0]    LAST_BIT = CNT_W'(FRAME_LEN - 1);
  localparam logic [MISS_W-1:0]   MISS_MAX = MISS_W'(LOSS_THRESH);
  localparam logic [SYNC_LEN-1:0] SYNC_PAT = SYNC_WORD[SYNC_LEN-1:0];

  descr_state_t        state_q, state_d;
  logic [SYNC_LEN-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
  logic [MISS_W-1:0]   miss_q, miss_d, miss_inc_c;
  logic                out_d, out_valid_d, frame_start_d, locked_d;
  logic                match_c, ks_c, lfsr_load_c, lfsr_step_c;

  descr_lfsr #(
    .POLY (POLY),
    .INIT (INIT)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load_c),
    .step (lfsr_step_c),
    .ks_c (ks_c)
  );

  assign miss_inc_c = miss_q + MISS_W'(1);

  // Next-state, counters and output values; match includes the bit arriving this cycle.
  always_comb begin
    state_d       = state_q;
    bitcnt_d      = bitcnt_q;
    miss_d        = miss_q;
    out_d         = out;
    out_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    lfsr_load_c   = 1'b0;
    lfsr_step_c   = 1'b0;
    shreg_d       = in_valid ? {shreg_q[SYNC_LEN-2:0], in} : shreg_q;
    match_c       = (shreg_d == SYNC_PAT);

    if (resync) begin
      state_d = HUNT;
      miss_d  = '0;
    end else if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          if (match_c) begin
            state_d     = LOCKED;
            lfsr_load_c = 1'b1;
            bitcnt_d    = '0;
            miss_d      = '0;
          end
        end
        LOCKED: begin
          if (bitcnt_q < PAY_END) begin
            out_d         = in ^ ks_c;
            out_valid_d   = 1'b1;
            frame_start_d = (bitcnt_q == '0);
            lfsr_step_c   = 1'b1;
            bitcnt_d      = bitcnt_q + CNT_W'(1);
          end else if (bitcnt_q == LAST_BIT) begin
            // Flywheel: the next frame always restarts from the seed, hit or miss.
            lfsr_load_c = 1'b1;
            bitcnt_d    = '0;
            if (match_c) begin
              miss_d = '0;
            end else if (miss_inc_c >= MISS_MAX) begin
              state_d = HUNT;
              miss_d  = '0;
            end else begin
              miss_d = miss_inc_c;
            end
          end else begin
            bitcnt_d = bitcnt_q + CNT_W'(1);
          end
        end
        default: state_d = HUNT;
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      shreg_q     <= '0;
      bitcnt_q    <= '0;
      miss_q      <= '0;
      out         <= 1'b0;
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bitcnt_q    <= bitcnt_d;
      miss_q      <= miss_d;
      out         <= out_d;
      out_valid   <= out_valid_d;
      frame_start <= frame_start_d;
      locked      <= locked_d;
    end
  end

`ifdef DESCR_ERR_CNT_EN
  logic err_inc_c;

  assign err_inc_c = in_valid && !resync && (state_q == LOCKED) &&
                     (bitcnt_q == LAST_BIT) && !match_c;

  // Lifetime miss count; only rst clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_err_cnt <= '0;
    end else if (err_inc_c && (sync_err_cnt != '1)) begin
      sync_err_cnt <= sync_err_cnt + ERR_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_additive_descrambler.sv
// Self-checking bench: random plaintext frames scrambled by a reference transmitter model.
module tb_additive_descrambler;

  localparam logic [31:0] T_POLY = 32'h0000_0060;
  localparam logic [31:0] T_INIT = 32'h0000_007F;
  localparam logic [31:0] T_SYNC = 32'h1ACF_FC1D;
  localparam int          PL     = 224;

  logic clk = 1'b0, rst = 1'b1, in = 1'b0, in_valid = 1'b0, resync = 1'b0;
  logic out, out_valid, frame_start, locked;
`ifdef DESCR_ERR_CNT_EN
  logic [15:0] sync_err_cnt;
`endif

  additive_descrambler dut (
    .clk         (clk),
    .rst         (rst),
    .in          (in),
    .in_valid    (in_valid),
    .resync      (resync),
    .out         (out),
    .out_valid   (out_valid),
    .frame_start (frame_start),
    .locked      (locked)
`ifdef DESCR_ERR_CNT_EN
    ,
    .sync_err_cnt(sync_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, fails = 0;
  bit ks_tab[PL];
  bit stream[$], plain[$], expq[$], got[$], lk[$];
  int got_at[$], fs_at[$];
  int gap_viol = 0, cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Transmitter keystream for one payload, straight from the tap-parity rule.
  function automatic void build_ks();
    logic [31:0] r;
    bit k;
    r = T_INIT;
    for (int i = 0; i < PL; i++) begin
      k = ^(r & T_POLY);
      ks_tab[i] = k;
      r = {r[30:0], k};
    end
  endfunction

  task automatic add_frame(input bit corrupt);
    logic [31:0] sw;
    int cb;
    bit p;
    sw = T_SYNC;
    if (corrupt) begin
      cb = $urandom_range(31, 0);
      sw[cb] = ~sw[cb];
    end
    for (int i = 31; i >= 0; i--) stream.push_back(sw[i]);
    for (int i = 0; i < PL; i++) begin
      p = 1'($urandom);
      plain.push_back(p);
      stream.push_back(p ^ ks_tab[i]);
    end
  endtask

  task automatic add_exp(input int f);
    for (int i = 0; i < PL; i++) expq.push_back(plain[f*PL + i]);
  endtask

  task automatic cycle(input bit b, input bit v, input bit rs);
    @(negedge clk);
    in = b; in_valid = v; resync = rs;
    @(posedge clk);
    #1;
    if (out_valid) begin got.push_back(out); got_at.push_back(cyc); end
    if (frame_start) fs_at.push_back(cyc);
    if (!v && (out_valid || frame_start)) gap_viol++;
    lk.push_back(locked);
    cyc++;
  endtask

  task automatic run_stream(input bit rand_gap);
    foreach (stream[i]) begin
      if (rand_gap && $urandom_range(1, 0) == 1) cycle(1'($urandom), 1'b0, 1'b0);
      cycle(stream[i], 1'b1, 1'b0);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; resync = 1'b0;
    #1;
    check({tag, "_rst_out"}, out, 0);
    check({tag, "_rst_vld"}, out_valid, 0);
    check({tag, "_rst_locked"}, locked, 0);
`ifdef DESCR_ERR_CNT_EN
    check({tag, "_rst_err"}, sync_err_cnt, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    got.delete(); got_at.delete(); fs_at.delete(); lk.delete(); expq.delete();
    cyc = 0; gap_viol = 0;
  endtask

  task automatic new_stream();
    stream.delete(); plain.delete();
  endtask

  task automatic cmp_payload(input string tag, input int from_cyc);
    int n, bad;
    n = 0; bad = 0;
    foreach (got[i]) begin
      if (got_at[i] > from_cyc) begin
        if (n < expq.size() && got[i] != expq[n]) bad++;
        n++;
      end
    end
    check({tag, "_count"}, n, expq.size());
    check({tag, "_bad_bits"}, bad, 0);
  endtask

  function automatic int first_lock(input int from);
    for (int i = from; i < lk.size(); i++) if (lk[i]) return i;
    return -1;
  endfunction

  initial begin
    int zeros;
    build_ks();

    // 1: clean stream, continuous valid
    do_reset("t1");
    new_stream();
    for (int f = 0; f < 4; f++) begin add_frame(1'b0); add_exp(f); end
    run_stream(1'b0);
    check("t1_lock_at", first_lock(0), 31);
    check("t1_fs_count", fs_at.size(), 4);
    if (fs_at.size() == 4) begin
      check("t1_fs_first", fs_at[0], 32);
      for (int i = 1; i < 4; i++) check("t1_fs_spacing", fs_at[i] - fs_at[i-1], 256);
    end
    cmp_payload("t1_payload", -1);

    // 2: same stream with random idle cycles
    do_reset("t2");
    for (int f = 0; f < 4; f++) add_exp(f);
    run_stream(1'b1);
    cmp_payload("t2_payload", -1);
    check("t2_gap_viol", gap_viol, 0);
    check("t2_fs_count", fs_at.size(), 4);

    // 3: two isolated sync errors keep lock
    do_reset("t3");
    new_stream();
    add_frame(1'b0); add_frame(1'b1); add_frame(1'b1); add_frame(1'b0);
    for (int f = 0; f < 4; f++) add_exp(f);
    run_stream(1'b0);
    check("t3_lock_at", first_lock(0), 31);
    zeros = 0;
    for (int i = 31; i < lk.size(); i++) if (!lk[i]) zeros++;
    check("t3_lock_drops", zeros, 0);
    cmp_payload("t3_payload", -1);
`ifdef DESCR_ERR_CNT_EN
    check("t3_err_cnt", sync_err_cnt, 2);
`endif

    // 4: three consecutive bad syncs lose lock, next good sync relocks
    do_reset("t4");
    new_stream();
    add_frame(1'b0); add_frame(1'b1); add_frame(1'b1);
    add_frame(1'b1); add_frame(1'b0); add_frame(1'b0);
    add_exp(0); add_exp(1); add_exp(2); add_exp(4); add_exp(5);
    run_stream(1'b0);
    check("t4_locked_before_loss", lk[798], 1);
    check("t4_locked_at_loss", lk[799], 0);
    check("t4_relock_before", lk[1054], 0);
    check("t4_relock_at", lk[1055], 1);
    cmp_payload("t4_payload", -1);
`ifdef DESCR_ERR_CNT_EN
    check("t4_err_cnt", sync_err_cnt, 3);
`endif

    // 5: false sync 100 bits ahead of the real frames
    do_reset("t5");
    new_stream();
    for (int i = 0; i < 20; i++) stream.push_back(1'($urandom));
    for (int i = 31; i >= 0; i--) stream.push_back(T_SYNC[i]);
    for (int i = 0; i < 100; i++) stream.push_back(1'($urandom));
    for (int f = 0; f < 5; f++) add_frame(1'b0);
    add_exp(3); add_exp(4);
    run_stream(1'b0);
    check("t5_false_lock_pre", lk[50], 0);
    check("t5_false_lock", lk[51], 1);
    check("t5_false_hold", lk[818], 1);
    check("t5_false_drop", lk[819], 0);
    check("t5_true_pre", lk[950], 0);
    check("t5_true_lock", lk[951], 1);
    cmp_payload("t5_payload", 951);
`ifdef DESCR_ERR_CNT_EN
    check("t5_err_cnt", sync_err_cnt, 3);
`endif

    // 6: resync and asynchronous reset mid-payload
    do_reset("t6");
    new_stream();
    add_frame(1'b0);
    for (int i = 0; i < 82; i++) cycle(stream[i], 1'b1, 1'b0);
    check("t6_locked_pre", locked, 1);
    check("t6_vld_pre", out_valid, 1);
    cycle(stream[82], 1'b1, 1'b1);
    check("t6_resync_locked", locked, 0);
    check("t6_resync_vld", out_valid, 0);
    cycle(stream[83], 1'b1, 1'b0);
    check("t6_hunt_vld", out_valid, 0);
    for (int i = 0; i < 82; i++) cycle(stream[i], 1'b1, 1'b0);
    check("t6_relock", locked, 1);
    check("t6_relock_vld", out_valid, 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t6_arst_out", out, 0);
    check("t6_arst_vld", out_valid, 0);
    check("t6_arst_fs", frame_start, 0);
    check("t6_arst_locked", locked, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
